// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline and the mult/div busy sequencer.
// Optional stall-cycle performance counter is built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic        D_md_use,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        stall,
  output logic        DE_flush,
  output logic        md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  md_state_e  state_q;
  logic [3:0] cnt_q;
  logic       md_busy_q;
  logic       rs_haz, rt_haz, md_haz;

  // A source hazards against a producer only if the producer's result arrives
  // later than the consumer needs it; $0 is hardwired and never hazards.
  function automatic logic src_haz(input logic [4:0] src, input logic [1:0] tuse,
                                   input logic [4:0] wa,  input logic [1:0] tnew);
    return (src != 5'd0) && (src == wa) && (tnew > tuse);
  endfunction

  always_comb begin
    rs_haz   = src_haz(D_rs, D_rs_tuse, E_wa, E_tnew) || src_haz(D_rs, D_rs_tuse, M_wa, M_tnew);
    rt_haz   = src_haz(D_rt, D_rt_tuse, E_wa, E_tnew) || src_haz(D_rt, D_rt_tuse, M_wa, M_tnew);
    md_haz   = D_md_use && (md_busy_q || E_md_start);
    stall    = rs_haz || rt_haz || md_haz;
    DE_flush = stall;
  end

  // Starts arriving while BUSY are ignored; a start is accepted even when D stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      md_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (E_md_start) begin
            state_q   <= BUSY;
            cnt_q     <= E_md_div ? DIV_LD : MULT_LD;
            md_busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q > 4'd1) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            md_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= 4'd0;
          md_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy = md_busy_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= 32'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
